noc_echo_responder: RTL and testbench

//  NoC endpoint that answers a compute tile: sinks request packets from the tile's noc_out, buffers one packet,
//  and returns it on the tile's noc_in with source/destination swapped. Serves as the far end of the tile link
//  in system benches and bring-up tiles. Shared flit bus, one-hot per-vchannel valid/ready, same as the tile.

---
 rtl/noc_echo_pkg.sv | 23 ++
 rtl/noc_echo_buffer.sv | 31 +++
 rtl/noc_echo_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_noc_echo_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_echo_pkg.sv
// Shared definitions for the NoC echo responder: flit type codes, header field
// positions and the controller state encoding.
package noc_echo_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    localparam int HDR_DEST_LSB  = 27;
    localparam int HDR_CLASS_LSB = 24;
    localparam int HDR_SRC_LSB   = 19;
    localparam int HDR_ADDR_W    = 5;
    localparam int HDR_CLASS_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_SEND = 2'd2,
        ST_DROP = 2'd3
    } state_e;

endpackage

// File: rtl/noc_echo_buffer.sv
// Packet store for the echo responder: DEPTH x WIDTH registers, one indexed
// write port and a combinational read port.
module noc_echo_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/noc_echo_responder.sv
// NoC echo endpoint: buffers one request packet and returns it with src/dest swapped.
// Optional NOC_ECHO_STATS_EN adds saturating pkt_count/drop_count outputs.
//
// state | meaning
// IDLE  | waiting for HEADER or SINGLE on VC_IN
// RECV  | collecting body flits into the buffer until LAST
// SEND  | replaying the buffered packet on VC_OUT, input blocked
// DROP  | packet overflowed the buffer, discarding through LAST
module noc_echo_responder
    import noc_echo_pkg::*;
#(
    parameter int ID                  = 0,
    parameter int NOC_FLIT_DATA_WIDTH = 32,
    parameter int NOC_FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS           = 3,
    parameter int VC_IN               = 0,
    parameter int VC_OUT              = 1,
    parameter int DEPTH               = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_sys_n,
    input  logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] in_flit,
    input  logic [VCHANNELS-1:0]                               in_valid,
    output logic [VCHANNELS-1:0]                               in_ready,
    output logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] out_flit,
    output logic [VCHANNELS-1:0]                               out_valid,
    input  logic [VCHANNELS-1:0]                               out_ready,
    output logic                                               err_seq
`ifdef NOC_ECHO_STATS_EN
    ,
    output logic [31:0]                                        pkt_count,
    output logic [15:0]                                        drop_count
`endif
);

    localparam int DW    = NOC_FLIT_DATA_WIDTH;
    localparam int TW    = NOC_FLIT_TYPE_WIDTH;
    localparam int FW    = DW + TW;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_q, rd_d;
    logic [LEN_W-1:0] rd_nxt;
    logic [FW-1:0]    out_flit_q, out_flit_d;
    logic             out_valid_q, out_valid_d;
    logic             err_seq_q, err_seq_d;
    logic             alive_q;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [FW-1:0]    rd_flit;
    logic             in_fire, out_fire, pkt_done, pkt_drop;
    logic [TW-1:0]    in_type;
    logic [DW-1:0]    in_data;
    logic             unused_sig;

    function automatic logic [DW-1:0] swap_hdr(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        r[HDR_DEST_LSB +: HDR_ADDR_W] = d[HDR_SRC_LSB +: HDR_ADDR_W];
        r[HDR_SRC_LSB  +: HDR_ADDR_W] = HDR_ADDR_W'(ID);
        return r;
    endfunction

    noc_echo_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (FW),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_sys_n),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (in_flit),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_flit)
    );

    // Input is held off only in SEND and during the cycle reset is asserted.
    always_comb begin
        in_ready        = '1;
        in_ready[VC_IN] = alive_q && (state_q != ST_SEND);
    end

    assign in_fire   = in_valid[VC_IN] & in_ready[VC_IN];
    assign out_fire  = out_valid_q & out_ready[VC_OUT];
    assign in_type   = in_flit[FW-1:DW];
    assign in_data   = in_flit[DW-1:0];
    assign rd_nxt    = rd_q + 1'b1;
    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q ? (VCHANNELS'(1) << VC_OUT) : '0;
    assign err_seq   = err_seq_q;
    assign unused_sig = ^{rd_flit[FW-1:DW], in_valid, out_ready};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_d        = rd_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        err_seq_d   = err_seq_q;
        wr_en       = 1'b0;
        wr_idx      = '0;
        pkt_done    = 1'b0;
        pkt_drop    = 1'b0;
        rd_idx      = (state_q == ST_SEND) ? rd_nxt[IDX_W-1:0] : '0;

        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_type == TW'(FLIT_HEADER)) begin
                        wr_en   = 1'b1;
                        len_d   = LEN_W'(1);
                        state_d = ST_RECV;
                    end else if (in_type == TW'(FLIT_SINGLE)) begin
                        wr_en       = 1'b1;
                        len_d       = LEN_W'(1);
                        rd_d        = '0;
                        out_valid_d = 1'b1;
                        out_flit_d  = {TW'(FLIT_SINGLE), swap_hdr(in_data)};
                        state_d     = ST_SEND;
                    end else begin
                        err_seq_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (in_fire) begin
                    if (in_type == TW'(FLIT_HEADER)) begin
                        err_seq_d = 1'b1;
                        wr_en     = 1'b1;
                        len_d     = LEN_W'(1);
                    end else if (in_type == TW'(FLIT_SINGLE)) begin
                        err_seq_d   = 1'b1;
                        wr_en       = 1'b1;
                        len_d       = LEN_W'(1);
                        rd_d        = '0;
                        out_valid_d = 1'b1;
                        out_flit_d  = {TW'(FLIT_SINGLE), swap_hdr(in_data)};
                        state_d     = ST_SEND;
                    end else if (len_q == LEN_W'(DEPTH)) begin
                        // A LAST that would be flit DEPTH+1 has nothing left to discard.
                        pkt_drop = 1'b1;
                        state_d  = (in_type == TW'(FLIT_LAST)) ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = len_q[IDX_W-1:0];
                        len_d  = len_q + 1'b1;
                        if (in_type == TW'(FLIT_LAST)) begin
                            rd_d        = '0;
                            out_valid_d = 1'b1;
                            out_flit_d  = {TW'(FLIT_HEADER), swap_hdr(rd_flit[DW-1:0])};
                            state_d     = ST_SEND;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (in_fire && in_type == TW'(FLIT_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_fire) begin
                    if (rd_nxt == len_q) begin
                        pkt_done    = 1'b1;
                        out_valid_d = 1'b0;
                        out_flit_d  = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_d       = rd_nxt;
                        out_flit_d = {(rd_nxt == len_q - 1'b1) ? TW'(FLIT_LAST) : TW'(FLIT_PAYLOAD),
                                      rd_flit[DW-1:0]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rd_q        <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            err_seq_q   <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            err_seq_q   <= err_seq_d;
            alive_q     <= 1'b1;
        end
    end

`ifdef NOC_ECHO_STATS_EN
    logic [31:0] pkt_count_q;
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (pkt_done && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 1'b1;
            if (pkt_drop && drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`else
    logic unused_stats;
    assign unused_stats = pkt_done ^ pkt_drop;
`endif

endmodule

// File: tb/tb_noc_echo_responder.sv
// Scoreboard bench for noc_echo_responder: directed packets push expected echoes,
// an independent monitor pops and compares whenever VC_OUT presents a flit.
module tb_noc_echo_responder;

    localparam int DW = 32, TW = 2, FW = 34, VC = 3;
    localparam int VC_IN = 0, VC_OUT = 1, DEPTH = 8, ID = 0;
    localparam logic [1:0] T_P = 2'b00, T_H = 2'b01, T_L = 2'b10, T_S = 2'b11;

    logic          clk = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic [VC-1:0] in_valid = '0;
    logic [VC-1:0] in_ready;
    logic [FW-1:0] out_flit;
    logic [VC-1:0] out_valid;
    logic [VC-1:0] out_ready;
    logic          err_seq;
`ifdef NOC_ECHO_STATS_EN
    logic [31:0]   pkt_count;
    logic [15:0]   drop_count;
`endif

    logic tog = 1'b0, tog_en = 1'b0, rdy_fix = 1'b1;
    assign out_ready = {1'b1, (tog_en ? tog : rdy_fix), 1'b1};

    int checks = 0;
    int passed = 0;
    logic [FW-1:0] exp_q [$];

    noc_echo_responder #(
        .ID (ID), .NOC_FLIT_DATA_WIDTH (DW), .NOC_FLIT_TYPE_WIDTH (TW),
        .VCHANNELS (VC), .VC_IN (VC_IN), .VC_OUT (VC_OUT), .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_sys_n (rst_sys_n),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_seq   (err_seq)
`ifdef NOC_ECHO_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 tog = ~tog;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] hdr(input logic [4:0] d, input logic [2:0] c,
                                        input logic [4:0] s, input logic [18:0] lo);
        return {d, c, s, lo};
    endfunction

    // Monitor: every cycle VC_OUT is valid the flit must equal the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (out_valid !== '0) begin
            chk("out_valid_onehot", 64'(out_valid), 64'(3'b010));
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got %0h expected no output", out_flit);
            end else begin
                chk("out_flit", 64'(out_flit), 64'(exp_q[0]));
                if (out_ready[VC_OUT]) void'(exp_q.pop_front());
            end
        end
    end

    // Starts and ends just after a rising edge; the flit is accepted on the edge it sees ready.
    task automatic send(input int vc, input logic [1:0] typ, input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        in_flit  = {typ, data};
        in_valid = VC'(1) << vc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready[vc]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_valid[VC_OUT] == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 64'(done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_err_seq", 64'(err_seq), 64'(0));
        chk("rst_in_ready_vcin", 64'(in_ready[VC_IN]), 64'(0));
        rst_sys_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready[VC_IN]), 64'(1));
        chk("in_ready_vc2", 64'(in_ready[2]), 64'(1));
`ifdef NOC_ECHO_STATS_EN
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));
`endif
        @(posedge clk);
        #1;

        // SINGLE: dest 1 / src 2 -> dest 2 / src ID, valid the cycle after acceptance
        exp_q.push_back({T_S, hdr(5'd2, 3'd2, 5'd0, 19'h00123)});
        send(VC_IN, T_S, hdr(5'd1, 3'd2, 5'd2, 19'h00123));
        @(negedge clk);
        chk("single_latency", 64'(out_valid[VC_OUT]), 64'(1));
        wait_drain();

        // 4-flit packet with toggling out_ready
        tog_en = 1'b1;
        exp_q.push_back({T_H, hdr(5'd7, 3'd5, 5'd0, 19'h00055)});
        exp_q.push_back({T_P, 32'h0000_0011});
        exp_q.push_back({T_P, 32'h0000_0022});
        exp_q.push_back({T_L, 32'h0000_0033});
        send(VC_IN, T_H, hdr(5'd3, 3'd5, 5'd7, 19'h00055));
        send(VC_IN, T_P, 32'h0000_0011);
        send(VC_IN, T_P, 32'h0000_0022);
        send(VC_IN, T_L, 32'h0000_0033);
        wait_drain();
        tog_en = 1'b0;

        // LAST in IDLE sets err_seq; next packet still echoed
        send(VC_IN, T_L, 32'h0000_0044);
        @(negedge clk);
        chk("err_seq_set", 64'(err_seq), 64'(1));
        chk("stray_last_no_out", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        exp_q.push_back({T_H, hdr(5'd9, 3'd1, 5'd0, 19'h00007)});
        exp_q.push_back({T_L, 32'h0000_0066});
        send(VC_IN, T_H, hdr(5'd4, 3'd1, 5'd9, 19'h00007));
        send(VC_IN, T_L, 32'h0000_0066);
        wait_drain();
        chk("err_seq_sticky", 64'(err_seq), 64'(1));

        // 10-flit packet overflows DEPTH=8: all accepted, no response
        send(VC_IN, T_H, hdr(5'd1, 3'd0, 5'd3, 19'h0));
        for (int i = 0; i < 8; i++) send(VC_IN, T_P, 32'(i));
        send(VC_IN, T_L, 32'h0000_00AA);
        repeat (4) @(negedge clk);
        chk("drop_no_out", 64'(out_valid), 64'(0));
        chk("drop_back_idle", 64'(in_ready[VC_IN]), 64'(1));
`ifdef NOC_ECHO_STATS_EN
        chk("drop_count", 64'(drop_count), 64'(1));
        chk("pkt_count", 64'(pkt_count), 64'(3));
`endif
        @(posedge clk);
        #1;

        // vchannel 2 traffic during a stalled SEND; VC_IN blocked until response done
        rdy_fix = 1'b0;
        exp_q.push_back({T_H, hdr(5'd6, 3'd3, 5'd0, 19'h00100)});
        exp_q.push_back({T_P, 32'hDEAD_BEEF});
        exp_q.push_back({T_L, 32'h1234_5678});
        send(VC_IN, T_H, hdr(5'd2, 3'd3, 5'd6, 19'h00100));
        send(VC_IN, T_P, 32'hDEAD_BEEF);
        send(VC_IN, T_L, 32'h1234_5678);
        @(negedge clk);
        chk("send_blocks_vcin", 64'(in_ready[VC_IN]), 64'(0));
        chk("send_vc2_ready", 64'(in_ready[2]), 64'(1));
        @(posedge clk);
        #1;
        send(2, T_S, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("vc2_still_blocked", 64'(in_ready[VC_IN]), 64'(0));
        @(posedge clk);
        #1;
        rdy_fix = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid[VC_OUT] && out_flit[FW-1:DW] == T_L) begin
                seen = 1'b1;
                chk("ready_not_same_cycle", 64'(in_ready[VC_IN]), 64'(0));
                @(negedge clk);
                chk("ready_after_resp", 64'(in_ready[VC_IN]), 64'(1));
                break;
            end
        end
        chk("last_seen", 64'(seen), 64'(1));
        wait_drain();

        // async reset in the middle of SEND
        rdy_fix = 1'b0;
        exp_q.push_back({T_S, hdr(5'd8, 3'd7, 5'd0, 19'h00042)});
        send(VC_IN, T_S, hdr(5'd3, 3'd7, 5'd8, 19'h00042));
        @(negedge clk);
        #2 rst_sys_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_out_flit", 64'(out_flit), 64'(0));
        chk("rst_mid_err_seq", 64'(err_seq), 64'(0));
        exp_q.delete();
        rdy_fix = 1'b1;
        @(negedge clk);
        rst_sys_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(in_ready[VC_IN]), 64'(1));
        @(posedge clk);
        #1;
        exp_q.push_back({T_S, hdr(5'd4, 3'd6, 5'd0, 19'h00001)});
        send(VC_IN, T_S, hdr(5'd0, 3'd6, 5'd4, 19'h00001));
        wait_drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
